com_tpram_pipe: RTL

COM_TPRAM_PIPE -- requirements
Module: com_tpram_pipe

---
 rtl/com_tpram_pipe.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/com_tpram_pipe.sv
// com_tpram_pipe -- two-port (one write, one read) RAM with per-lane write
// strobes, write-first same-address read bypass, configurable read pipeline
// latency and an automatic/on-request memory clear sequence.
//
// Ports
//   clk        single clock for all logic
//   rst_n      asynchronous active-low reset (memory array is not reset)
//   wr_en      per-lane write enable, lane i covers wr_data[i*SUB_DW +: SUB_DW]
//   wr_addr    write address (addresses >= DEPTH are discarded)
//   wr_data    write data
//   rd_en      read request
//   rd_addr    read address (addresses >= DEPTH read back as zero)
//   rd_data    read data, RD_LAT cycles after rd_en; holds last valid value
//   rd_vld     rd_data carries a fresh read result this cycle
//   init_req   single-cycle pulse requesting a memory clear
//   init_busy  clear sequence in progress; user reads/writes are ignored
module com_tpram_pipe #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 64,
  parameter int unsigned       STRB_W   = 1,
  parameter int unsigned       RD_LAT   = 1,
  parameter bit                INIT_EN  = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  localparam int unsigned      ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [STRB_W-1:0] wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_vld,
  input  logic              init_req,
  output logic              init_busy
);

  localparam int unsigned       SUB_DW    = DATA_W / STRB_W;
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    INIT
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] init_cnt;
  logic              init_pend;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_ok;
  logic              rd_addr_ok;
  logic              s0_vld;
  logic [DATA_W-1:0] s0_dat;

  logic [RD_LAT-1:0] vld_q;
  logic [DATA_W-1:0] dat_q [RD_LAT];

  assign init_busy  = (state == INIT);
  assign wr_ok      = (state == IDLE) && ({1'b0, wr_addr} < DEPTH_X);
  assign rd_addr_ok = ({1'b0, rd_addr} < DEPTH_X);
  assign s0_vld     = (state == IDLE) && rd_en;

  // init_pend makes the post-reset clear start on the first edge after
  // release; it is consumed on that edge whether or not INIT_EN is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      init_cnt  <= '0;
      init_pend <= INIT_EN;
    end else begin
      case (state)
        IDLE: begin
          init_pend <= 1'b0;
          if (init_req || init_pend) begin
            state    <= INIT;
            init_cnt <= '0;
          end
        end
        INIT: begin
          if (init_cnt == LAST_ADDR) begin
            state    <= IDLE;
            init_cnt <= '0;
          end else begin
            init_cnt <= init_cnt + ADDR_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          init_cnt <= '0;
        end
      endcase
    end
  end

  // Memory array: no reset, clear sequence has priority over user writes.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[init_cnt] <= INIT_VAL;
    end else if (wr_ok) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (wr_en[i]) begin
          mem[wr_addr][i*SUB_DW +: SUB_DW] <= wr_data[i*SUB_DW +: SUB_DW];
        end
      end
    end
  end

  // Read stage 0: write-first bypass per lane on an address match.
  always_comb begin
    s0_dat = '0;
    if (rd_addr_ok) begin
      s0_dat = mem[rd_addr];
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (wr_ok && wr_en[i] && (wr_addr == rd_addr)) begin
          s0_dat[i*SUB_DW +: SUB_DW] = wr_data[i*SUB_DW +: SUB_DW];
        end
      end
    end
  end

  // Every data stage only loads when its incoming valid is set, so the last
  // stage naturally holds the most recent valid result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int unsigned k = 0; k < RD_LAT; k++) begin
        dat_q[k] <= '0;
      end
    end else begin
      vld_q[0] <= s0_vld;
      if (s0_vld) begin
        dat_q[0] <= s0_dat;
      end
      for (int unsigned k = 1; k < RD_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) begin
          dat_q[k] <= dat_q[k-1];
        end
      end
    end
  end

  assign rd_vld  = vld_q[RD_LAT-1];
  assign rd_data = dat_q[RD_LAT-1];

endmodule
